// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: shared 640x480 timing constants.
// Reused by the sync generator, porch and sync-to-count stages.
package vga_timing_pkg;

  localparam int TOTAL_COLS       = 800;
  localparam int TOTAL_ROWS       = 525;
  localparam int ACTIVE_COLS      = 640;
  localparam int ACTIVE_ROWS      = 480;
  localparam int FRONT_PORCH_HORZ = 18;
  localparam int BACK_PORCH_HORZ  = 50;
  localparam int FRONT_PORCH_VERT = 10;
  localparam int BACK_PORCH_VERT  = 33;
  localparam int COUNT_WIDTH      = 10;

endpackage

// File: rtl/vga_timing_gen_axis.sv
// timing_axis_counter: one axis of the raster scan.
// Wrapping counter with carry and next-state window decode.
module timing_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int TOTAL       = TOTAL_COLS,
  parameter int ACTIVE      = ACTIVE_COLS,
  parameter int FRONT_PORCH = FRONT_PORCH_HORZ,
  parameter int BACK_PORCH  = BACK_PORCH_HORZ,
  parameter int W           = COUNT_WIDTH
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         carry,
  output logic         nxt_active,
  output logic         nxt_sync_n
);

  localparam logic [W-1:0] LAST     = W'(TOTAL - 1);
  localparam logic [W-1:0] ACT_END  = W'(ACTIVE);
  localparam logic [W-1:0] SYNC_ON  = W'(ACTIVE + FRONT_PORCH);
  localparam logic [W-1:0] SYNC_OFF = W'(TOTAL - BACK_PORCH);

  logic [W-1:0] nxt_count;

  // Decode from the next count so flags align with the registered count.
  always_comb begin
    carry     = step && (count == LAST);
    nxt_count = count;
    if (step) nxt_count = carry ? '0 : count + W'(1);
    nxt_active = nxt_count < ACT_END;
    nxt_sync_n = !((nxt_count >= SYNC_ON) &&
                   (nxt_count < SYNC_OFF));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) count <= LAST;
    else       count <= nxt_count;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running VGA raster timing.
// Registered counters, syncs, data-enable and start strobes.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int TOTAL_COLS       = vga_timing_pkg::TOTAL_COLS,
  parameter int TOTAL_ROWS       = vga_timing_pkg::TOTAL_ROWS,
  parameter int ACTIVE_COLS      = vga_timing_pkg::ACTIVE_COLS,
  parameter int ACTIVE_ROWS      = vga_timing_pkg::ACTIVE_ROWS,
  parameter int FRONT_PORCH_HORZ = vga_timing_pkg::FRONT_PORCH_HORZ,
  parameter int BACK_PORCH_HORZ  = vga_timing_pkg::BACK_PORCH_HORZ,
  parameter int FRONT_PORCH_VERT = vga_timing_pkg::FRONT_PORCH_VERT,
  parameter int BACK_PORCH_VERT  = vga_timing_pkg::BACK_PORCH_VERT,
  parameter int COUNT_WIDTH      = vga_timing_pkg::COUNT_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   enable,
  output logic                   ohsync,
  output logic                   ovsync,
  output logic                   oactive,
  output logic [COUNT_WIDTH-1:0] col,
  output logic [COUNT_WIDTH-1:0] row,
  output logic                   line_start,
  output logic                   frame_start
);

  logic h_wrap, h_act, h_sync_n;
  logic v_wrap, v_act, v_sync_n;

  timing_axis_counter #(
    .TOTAL      (TOTAL_COLS),
    .ACTIVE     (ACTIVE_COLS),
    .FRONT_PORCH(FRONT_PORCH_HORZ),
    .BACK_PORCH (BACK_PORCH_HORZ),
    .W          (COUNT_WIDTH)
  ) u_horz (
    .clock     (clock),
    .reset     (reset),
    .step      (enable),
    .count     (col),
    .carry     (h_wrap),
    .nxt_active(h_act),
    .nxt_sync_n(h_sync_n)
  );

  timing_axis_counter #(
    .TOTAL      (TOTAL_ROWS),
    .ACTIVE     (ACTIVE_ROWS),
    .FRONT_PORCH(FRONT_PORCH_VERT),
    .BACK_PORCH (BACK_PORCH_VERT),
    .W          (COUNT_WIDTH)
  ) u_vert (
    .clock     (clock),
    .reset     (reset),
    .step      (h_wrap),
    .count     (row),
    .carry     (v_wrap),
    .nxt_active(v_act),
    .nxt_sync_n(v_sync_n)
  );

  // A horizontal wrap only happens on an enabled edge entering col 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ohsync      <= 1'b1;
      ovsync      <= 1'b1;
      oactive     <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      ohsync      <= h_sync_n;
      ovsync      <= v_sync_n;
      oactive     <= h_act && v_act;
      line_start  <= h_wrap;
      frame_start <= h_wrap && v_wrap;
    end
  end

endmodule
